// File: rtl/march_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : march_bist_ctrl
// Purpose  : March C- built-in self-test controller for one port of a RAM.
//            Runs E0 up(w0); E1 up(r0,w1); E2 up(r1,w0); E3 down(r0,w1);
//            E4 down(r1,w0); E5 up(r0) once per start pulse. It checks the
//            registered read data one cycle after each read and reports
//            pass/fail plus the first failing address/expected/actual word.
// Ports    : clk        - single clock (RAM port shares it)
//            reset      - asynchronous active-low reset
//            start      - test start pulse, honoured only when idle
//            busy       - high while the march sequence is running
//            done       - one-cycle pulse at end of test
//            pass/fail  - sticky results, cleared on start
//            fail_addr/fail_exp/fail_act - capture of the first mismatch
//            mem_we/mem_re/mem_addr/mem_din - RAM port drive
//            mem_dout   - RAM read data, valid the cycle after mem_re
// Revision : 1.0 - initial release
// ============================================================================
module march_bist_ctrl #(
    parameter int DATA_WIDTH   = 4,
    parameter int ADDR_WIDTH   = 4,
    parameter bit STOP_ON_FAIL = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [DATA_WIDTH-1:0] fail_exp,
    output logic [DATA_WIDTH-1:0] fail_act,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_w0    = 3'd1;
    localparam logic [2:0] c_st_rd    = 3'd2;
    localparam logic [2:0] c_st_wr    = 3'd3;
    localparam logic [2:0] c_st_drain = 3'd4;
    localparam logic [2:0] c_st_done  = 3'd5;

    localparam logic [ADDR_WIDTH-1:0] c_addr_first = '0;
    localparam logic [ADDR_WIDTH-1:0] c_addr_last  = '1;
    localparam logic [ADDR_WIDTH-1:0] c_addr_one   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] c_zeros      = '0;
    localparam logic [DATA_WIDTH-1:0] c_ones       = '1;

    logic [2:0]            r_state, w_state_nxt;
    logic [2:0]            r_elem,  w_elem_nxt;
    logic [ADDR_WIDTH-1:0] r_addr,  w_addr_nxt;
    logic                  r_cmp_pending;
    logic [ADDR_WIDTH-1:0] r_cmp_addr;
    logic [DATA_WIDTH-1:0] r_cmp_exp;
    logic                  r_pass, r_fail;
    logic [ADDR_WIDTH-1:0] r_fail_addr;
    logic [DATA_WIDTH-1:0] r_fail_exp, r_fail_act;

    logic                  w_down;
    logic                  w_elem_end;
    logic [DATA_WIDTH-1:0] w_rd_exp;
    logic                  w_mismatch;

    // E3/E4 walk the array downwards; all other elements walk upwards.
    assign w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
    assign w_elem_end = w_down ? (r_addr == c_addr_first) : (r_addr == c_addr_last);
    // E2/E4 expect the all-ones background; E1/E3/E5 expect all-zeros.
    // The write in each r,w pair stores the complement of what was read.
    assign w_rd_exp   = r_elem[0] ? c_zeros : c_ones;
    // Only the first mismatch is of interest; later ones are ignored.
    assign w_mismatch = r_cmp_pending && (mem_dout != r_cmp_exp) && !r_fail;

    always_comb begin
        w_state_nxt = r_state;
        w_elem_nxt  = r_elem;
        w_addr_nxt  = r_addr;
        case (r_state)
            c_st_idle: begin
                if (start) begin
                    w_state_nxt = c_st_w0;
                    w_elem_nxt  = 3'd0;
                    w_addr_nxt  = c_addr_first;
                end
            end
            c_st_w0: begin
                if (r_addr == c_addr_last) begin
                    w_state_nxt = c_st_rd;
                    w_elem_nxt  = 3'd1;
                    w_addr_nxt  = c_addr_first;
                end else begin
                    w_addr_nxt  = r_addr + c_addr_one;
                end
            end
            c_st_rd: begin
                if (r_elem == 3'd5) begin
                    // E5 is read-only: stay in RD, stepping up to the top.
                    if (r_addr == c_addr_last) begin
                        w_state_nxt = c_st_drain;
                    end else begin
                        w_addr_nxt  = r_addr + c_addr_one;
                    end
                end else begin
                    w_state_nxt = c_st_wr;
                end
            end
            c_st_wr: begin
                w_state_nxt = c_st_rd;
                if (w_elem_end) begin
                    w_elem_nxt = r_elem + 3'd1;
                    // Entering E3 or E4 starts from the top of the array.
                    w_addr_nxt = ((r_elem == 3'd2) || (r_elem == 3'd3)) ? c_addr_last
                                                                        : c_addr_first;
                end else begin
                    w_addr_nxt = w_down ? (r_addr - c_addr_one) : (r_addr + c_addr_one);
                end
            end
            c_st_drain: begin
                // Gives the final E5 read its compare cycle.
                w_state_nxt = c_st_done;
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
                w_elem_nxt  = 3'd0;
                w_addr_nxt  = c_addr_first;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (STOP_ON_FAIL && w_mismatch) begin
            w_state_nxt = c_st_done;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_st_idle;
            r_elem        <= 3'd0;
            r_addr        <= c_addr_first;
            r_cmp_pending <= 1'b0;
            r_cmp_addr    <= c_addr_first;
            r_cmp_exp     <= c_zeros;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_addr   <= c_addr_first;
            r_fail_exp    <= c_zeros;
            r_fail_act    <= c_zeros;
        end else begin
            r_state       <= w_state_nxt;
            r_elem        <= w_elem_nxt;
            r_addr        <= w_addr_nxt;
            r_cmp_pending <= (r_state == c_st_rd);
            if (r_state == c_st_rd) begin
                r_cmp_addr <= r_addr;
                r_cmp_exp  <= w_rd_exp;
            end
            if ((r_state == c_st_idle) && start) begin
                r_pass      <= 1'b0;
                r_fail      <= 1'b0;
                r_fail_addr <= c_addr_first;
                r_fail_exp  <= c_zeros;
                r_fail_act  <= c_zeros;
            end else begin
                if (w_mismatch) begin
                    r_fail      <= 1'b1;
                    r_fail_addr <= r_cmp_addr;
                    r_fail_exp  <= r_cmp_exp;
                    r_fail_act  <= mem_dout;
                end
                // The last compare may flag a mismatch on the same edge that
                // enters DONE, so the verdict folds that in.
                if ((w_state_nxt == c_st_done) && (r_state != c_st_done)) begin
                    r_pass <= !(r_fail || w_mismatch);
                end
            end
        end
    end

    assign busy      = (r_state == c_st_w0) || (r_state == c_st_rd) ||
                       (r_state == c_st_wr) || (r_state == c_st_drain);
    assign done      = (r_state == c_st_done);
    assign pass      = r_pass;
    assign fail      = r_fail;
    assign fail_addr = r_fail_addr;
    assign fail_exp  = r_fail_exp;
    assign fail_act  = r_fail_act;
    assign mem_we    = (r_state == c_st_w0) || (r_state == c_st_wr);
    assign mem_re    = (r_state == c_st_rd);
    assign mem_addr  = r_addr;
    assign mem_din   = (r_state == c_st_wr) ? ~w_rd_exp : c_zeros;

endmodule
`default_nettype wire
